dtw_traceback_unit: RTL
=======================

Name: dtw_traceback_unit

Overview:
Parametrised DTW path-traceback engine. Replaces the one-cell-per-grid-point scoring cells with a single block holding the full TLEN x RLEN direction-code grid. The forward DTW array writes one 2-bit code per cell. On start, the block walks back from (TLEN-1, RLEN-1) to (0,0) and streams the visited index pairs to the SRAM writer over a valid/ready handshake.

Parameters:
TLEN, 32, test-sequence length (grid rows), >=2
RLEN, 32, reference-sequence length (grid columns), >=2
TW, $clog2(TLEN), row index width
RW, $clog2(RLEN), column index width
LW, $clog2(TLEN+RLEN), path-length counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_wr_en  in  1  write i_path into grid cell (i_tindex, i_rindex)
i_tindex  in  TW  write row index
i_rindex  in  RW  write column index
i_path  in  2  direction code: 11 = (i-1,j-1), 10 = (i-1,j), 01 = (i,j-1), 00 = none
i_start  in  1  one-cycle pulse; begin traceback
o_busy  out  1  high in TRACE and DONE
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts beat
o_tindex  out  TW  current path row
o_rindex  out  RW  current path column
o_last  out  1  marks the final beat of the path
o_done  out  1  one-cycle pulse at traceback completion
o_len  out  LW  number of beats emitted by the last traceback
o_err  out  1  sticky invalid-path flag (see Optional Feature)

Behaviour:
- Reset:
  - grid cleared to 00; state IDLE.
  - cur = (0,0).
  - o_valid, o_last, o_done, o_len, o_err all 0.
  - Reset mid-trace aborts immediately; no further beats.
- States:
  - IDLE -> TRACE on i_start.
  - TRACE -> DONE on the transfer of the last beat.
  - DONE -> IDLE unconditionally after 1 cycle.
- Writes:
  - Accepted only in IDLE; ignored in TRACE/DONE.
  - Out-of-range indices are ignored.
  - If i_wr_en and i_start arrive in the same cycle, the write commits and the traceback sees it.
- Start:
  - i_start in IDLE: cur <= (TLEN-1, RLEN-1), len <= 0, o_err <= 0.
  - i_start outside IDLE is ignored.
- TRACE:
  - o_valid = 1 with o_tindex/o_rindex = cur.
  - Beat, index and o_last stay stable until i_ready; a transfer occurs when o_valid & i_ready.
  - Each transfer increments len.
  - If cur == (0,0): o_last = 1 on that beat, then go to DONE.
  - Otherwise cur moves by code[cur]:
    - at i == 0, move is forced to j-1;
    - at j == 0, move is forced to i-1;
    - otherwise 11 -> (i-1,j-1), 10 -> (i-1,j), 01 -> (i,j-1), 00 -> (i-1,j-1).
- Throughput: one beat per cycle with i_ready held high. First o_valid appears in the cycle after the i_start edge.
- Path length is bounded to max(TLEN,RLEN) .. TLEN+RLEN-1 beats.
- DONE:
  - o_done high for 1 cycle; o_valid = 0.
  - o_len = len, held until the next start.
- Grid is retained after a traceback; a new i_start replays the same path.

Optional Feature:
- Macro DTW_TB_ERRCHK_EN.
- Enabled: a cell is illegal if its code is 00 at any cell other than (0,0), or if it is 11/10 at i == 0, or 11/01 at j == 0.
  - Transferring the beat of an illegal cell sets o_err (sticky until the next start).
  - That beat is marked o_last, and the state goes to DONE.
- Disabled: codes are substituted as in Behaviour and o_err is tied to 0.

Decomposition:
- Shared package dtw_pkg holds:
  - path code localparams PATH0 = 2'b11, PATH1 = 2'b10, PATH2 = 2'b01, PATH_RST = 2'b00;
  - traceback state encoding: IDLE, TRACE, DONE.
- One sub-module, dtw_tb_pathmem: TLEN x RLEN x 2 register grid with a synchronous write port, asynchronous clear on rst, and a combinational read at cur.

Test Plan:
- TLEN = RLEN = 4, all interior cells 11, i_ready = 1, start -> beats (3,3),(2,2),(1,1),(0,0); o_last on the 4th beat; o_done the next cycle; o_len = 4.
- Row 3 = 01, all others 10, start -> (3,3),(3,2),(3,1),(3,0),(2,0),(1,0),(0,0); o_len = 7.
- Diagonal grid with i_ready toggling 1,0,0,1,... -> o_valid and index held through stalls; identical sequence; no beat duplicated or dropped.
- i_start and i_wr_en pulsed during TRACE -> both ignored; path is unchanged; a restart afterwards replays it with o_len equal.
- rst asserted on the 2nd beat -> o_valid = 0 immediately, state IDLE, grid zero; a subsequent start walks (3,3),(2,2),(1,1),(0,0).
- With DTW_TB_ERRCHK_EN, cell (2,2) = 00 -> beats (3,3),(2,2); o_last on (2,2); o_err = 1; o_len = 2.

Source files
------------

// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW traceback engine: direction codes and
// traceback state encoding.
package dtw_pkg;

    // Direction codes written by the forward DTW array, one per grid cell.
    localparam logic [1:0] PATH0    = 2'b11;  // diagonal predecessor (i-1, j-1)
    localparam logic [1:0] PATH1    = 2'b10;  // upper predecessor    (i-1, j)
    localparam logic [1:0] PATH2    = 2'b01;  // left predecessor     (i, j-1)
    localparam logic [1:0] PATH_RST = 2'b00;  // no predecessor recorded

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACE = 2'd1,
        DONE  = 2'd2
    } tb_state_e;

endpackage

// File: rtl/dtw_tb_pathmem.sv
// Direction-code grid: TLEN x RLEN cells of 2 bits, synchronous write,
// asynchronous clear on rst, combinational read at the traceback cursor.
module dtw_tb_pathmem
    import dtw_pkg::*;
#(
    parameter int TLEN = 32,
    parameter int RLEN = 32,
    parameter int TW   = $clog2(TLEN),
    parameter int RW   = $clog2(RLEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [TW-1:0] wr_t_i,
    input  logic [RW-1:0] wr_r_i,
    input  logic [1:0]    wr_code_i,
    input  logic [TW-1:0] rd_t_i,
    input  logic [RW-1:0] rd_r_i,
    output logic [1:0]    rd_code_o
);

    logic [1:0] grid_q [TLEN][RLEN];
    logic       wr_in_range;
    logic       rd_in_range;

    assign wr_in_range = (int'(wr_t_i) < TLEN) && (int'(wr_r_i) < RLEN);
    assign rd_in_range = (int'(rd_t_i) < TLEN) && (int'(rd_r_i) < RLEN);

    // Grid storage: cleared on reset, one in-range cell written per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned t = 0; t < TLEN; t++) begin
                for (int unsigned r = 0; r < RLEN; r++) begin
                    grid_q[t][r] <= PATH_RST;
                end
            end
        end else if (wr_en_i && wr_in_range) begin
            grid_q[wr_t_i][wr_r_i] <= wr_code_i;
        end
    end

    // Combinational read of the cell under the cursor.
    always_comb begin
        rd_code_o = PATH_RST;
        if (rd_in_range) begin
            rd_code_o = grid_q[rd_t_i][rd_r_i];
        end
    end

endmodule

// File: rtl/dtw_traceback_unit.sv
// DTW path-traceback engine. Holds the full direction-code grid and, on
// i_start, walks from (TLEN-1, RLEN-1) back to (0,0), streaming each visited
// cell over a valid/ready handshake.
// Optional illegal-code detection is compiled in with DTW_TB_ERRCHK_EN.
module dtw_traceback_unit
    import dtw_pkg::*;
#(
    parameter int TLEN = 32,
    parameter int RLEN = 32,
    parameter int TW   = $clog2(TLEN),
    parameter int RW   = $clog2(RLEN),
    parameter int LW   = $clog2(TLEN + RLEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [TW-1:0] i_tindex,
    input  logic [RW-1:0] i_rindex,
    input  logic [1:0]    i_path,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [TW-1:0] o_tindex,
    output logic [RW-1:0] o_rindex,
    output logic          o_last,
    output logic          o_done,
    output logic [LW-1:0] o_len,
    output logic          o_err
);

    tb_state_e     state_q, state_d;
    logic [TW-1:0] cur_t_q, cur_t_d;
    logic [RW-1:0] cur_r_q, cur_r_d;
    logic [LW-1:0] len_q, len_d;
    logic [1:0]    code;
    logic          at_origin;
    logic          last_cell;
`ifdef DTW_TB_ERRCHK_EN
    logic          err_q, err_d;
    logic          illegal;
`endif

    dtw_tb_pathmem #(
        .TLEN (TLEN),
        .RLEN (RLEN),
        .TW   (TW),
        .RW   (RW)
    ) u_pathmem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (i_wr_en && (state_q == IDLE)),
        .wr_t_i    (i_tindex),
        .wr_r_i    (i_rindex),
        .wr_code_i (i_path),
        .rd_t_i    (cur_t_q),
        .rd_r_i    (cur_r_q),
        .rd_code_o (code)
    );

    assign at_origin = (cur_t_q == '0) && (cur_r_q == '0);

`ifdef DTW_TB_ERRCHK_EN
    // A code is illegal if it is missing off-origin, or points outside the grid.
    assign illegal = ((code == PATH_RST) && !at_origin)
                   || ((cur_t_q == '0) && code[1])
                   || ((cur_r_q == '0) && code[0]);
    assign last_cell = at_origin || illegal;
`else
    assign last_cell = at_origin;
`endif

    // State, cursor, length and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_t_q <= '0;
            cur_r_q <= '0;
            len_q   <= '0;
`ifdef DTW_TB_ERRCHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cur_t_q <= cur_t_d;
            cur_r_q <= cur_r_d;
            len_q   <= len_d;
`ifdef DTW_TB_ERRCHK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state, cursor stepping and beat accounting.
    always_comb begin
        state_d = state_q;
        cur_t_d = cur_t_q;
        cur_r_d = cur_r_q;
        len_d   = len_q;
`ifdef DTW_TB_ERRCHK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = TRACE;
                    cur_t_d = TW'(TLEN - 1);
                    cur_r_d = RW'(RLEN - 1);
                    len_d   = '0;
`ifdef DTW_TB_ERRCHK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            TRACE: begin
                if (i_ready) begin
                    len_d = len_q + 1'b1;
                    if (last_cell) begin
                        state_d = DONE;
`ifdef DTW_TB_ERRCHK_EN
                        err_d   = err_q | illegal;
`endif
                    end else if (cur_t_q == '0) begin
                        cur_r_d = cur_r_q - 1'b1;
                    end else if (cur_r_q == '0) begin
                        cur_t_d = cur_t_q - 1'b1;
                    end else begin
                        case (code)
                            PATH1: cur_t_d = cur_t_q - 1'b1;
                            PATH2: cur_r_d = cur_r_q - 1'b1;
                            PATH0, PATH_RST: begin
                                cur_t_d = cur_t_q - 1'b1;
                                cur_r_d = cur_r_q - 1'b1;
                            end
                        endcase
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_busy   = (state_q != IDLE);
    assign o_valid  = (state_q == TRACE);
    assign o_tindex = cur_t_q;
    assign o_rindex = cur_r_q;
    assign o_last   = o_valid && last_cell;
    assign o_done   = (state_q == DONE);
    assign o_len    = len_q;
`ifdef DTW_TB_ERRCHK_EN
    assign o_err    = err_q;
`else
    assign o_err    = 1'b0;
`endif

endmodule
